// File: rtl/pulse_width_meter.sv
// Multi-channel pulse-width meter: counts active-level cycles per channel and strobes done with the result.
// Optional 2-flop input synchroniser enabled by defining PULSE_WIDTH_METER_SYNC_EN.
module pulse_width_meter #(
    parameter int CHANNELS    = 1,
    parameter int WIDTH       = 16,
    parameter bit ACTIVE_HIGH = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [CHANNELS-1:0]         pulse_in,
    output logic [CHANNELS*WIDTH-1:0]   width_out,
    output logic [CHANNELS-1:0]         done,
    output logic [CHANNELS-1:0]         overflow,
    output logic [CHANNELS-1:0]         busy
);

    localparam logic [0:0]       IDLE     = 1'b0;
    localparam logic [0:0]       COUNT    = 1'b1;
    localparam logic             INACTIVE = ACTIVE_HIGH ? 1'b0 : 1'b1;
    localparam logic [WIDTH-1:0] CNT_ONE  = 1;
    localparam logic [WIDTH-1:0] CNT_MAX  = '1;

    logic [CHANNELS-1:0] s;
    logic [CHANNELS-1:0] a;

`ifdef PULSE_WIDTH_METER_SYNC_EN
    logic [CHANNELS-1:0] sync1;
    logic [CHANNELS-1:0] sync2;

    // Flops reset to the inactive level so reset release never looks like a pulse edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= {CHANNELS{INACTIVE}};
            sync2 <= {CHANNELS{INACTIVE}};
        end else begin
            sync1 <= pulse_in;
            sync2 <= sync1;
        end
    end

    assign s = sync2;
`else
    assign s = pulse_in;
`endif

    assign a = ACTIVE_HIGH ? s : ~s;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic [0:0]       state;
        logic             prev;
        logic [WIDTH-1:0] cnt;
        logic             sat;
        logic [WIDTH-1:0] result;
        logic             ovf_r;
        logic             done_r;
        logic             busy_r;

        // NOTE: every register here, including the published result, gets an explicit reset
        // value; prev resets to 1 so a pulse already active at reset release is ignored.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state  <= IDLE;
                prev   <= 1'b1;
                cnt    <= '0;
                sat    <= 1'b0;
                result <= '0;
                ovf_r  <= 1'b0;
                done_r <= 1'b0;
                busy_r <= 1'b0;
            end else begin
                // NOTE: non-blocking assignments so all flops update from pre-edge values.
                prev   <= a[i];
                done_r <= 1'b0;
                case (state)
                    IDLE: begin
                        if (a[i] && !prev) begin
                            cnt    <= CNT_ONE;
                            sat    <= 1'b0;
                            state  <= COUNT;
                            busy_r <= 1'b1;
                        end
                    end
                    COUNT: begin
                        if (a[i]) begin
                            if (cnt != CNT_MAX) cnt <= cnt + CNT_ONE;
                            else                sat <= 1'b1;
                        end else begin
                            result <= cnt;
                            ovf_r  <= sat;
                            done_r <= 1'b1;
                            state  <= IDLE;
                            busy_r <= 1'b0;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                    end
                endcase
            end
        end

        assign width_out[i*WIDTH +: WIDTH] = result;
        assign overflow[i]                 = ovf_r;
        assign done[i]                     = done_r;
        assign busy[i]                     = busy_r;
    end

endmodule

// File: doc/pulse_width_meter.md
# pulse_width_meter

Multi-channel pulse-width measurement block: for each channel it counts the clock cycles an input stays at its active level and publishes the result with a one-cycle `done` strobe. Used wherever the design times external pulses, such as the ultrasonic echo and button-hold timing. It is the parametrised successor of the single-channel cycle counter, adding:

- per-channel independence,
- configurable width and polarity,
- saturation with an overflow flag,
- asynchronous reset,
- an optional input synchroniser.

## Interface
- `CHANNELS`, 1 — number of independent measurement channels (≥1).
- `WIDTH`, 16 — counter and result width per channel (≥2).
- `ACTIVE_HIGH`, 1 — 1: measure high pulses; 0: measure low pulses (same for all channels).

- `clk`  in  1  — single clock; all state updates on rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `pulse_in`  in  CHANNELS  — raw pulse inputs; bit i is channel i.
- `width_out`  out  CHANNELS*WIDTH  — last completed measurement; channel i at bits [i*WIDTH +: WIDTH].
- `done`  out  CHANNELS  — one-cycle strobe: channel i's `width_out` just updated.
- `overflow`  out  CHANNELS  — qualifies the last result of channel i: 1 = saturated; valid with/after `done`.
- `busy`  out  CHANNELS  — channel i is currently counting.

## Operation
- **Active level.** Per channel, `s` = sampled input (see Configuration), XORed so that `a` = 1 means active level.
- **Edge history.** `prev` holds `a` from the previous cycle. `prev` resets to 1, so a pulse already active at reset release is ignored. Measurement starts only on an inactive→active transition.
- **FSM per channel, IDLE.** If `a`=1 and `prev`=0: `cnt`←1, `sat`←0, go to COUNT. Otherwise hold.
- **FSM per channel, COUNT, `a`=1.**
  - If `cnt` < 2^WIDTH−1: `cnt`←`cnt`+1.
  - Else `cnt` holds at 2^WIDTH−1 and `sat`←1.
- **FSM per channel, COUNT, `a`=0.** `width_out[i]`←`cnt`, `overflow[i]`←`sat`, `done[i]`←1, go to IDLE.
- **Outputs.**
  - `done[i]` is 0 in every other cycle.
  - `busy[i]` = (state==COUNT), registered.
  - `width_out` and `overflow` hold their value until the next `done`.
- **Result semantics.** Result = number of active samples in the pulse, with no off-by-one. A 1-cycle pulse gives 1. Saturated results read 2^WIDTH−1 with `overflow`=1.
- **Channel independence.** Channels never interact. Simultaneous completions on several channels assert several `done` bits in the same cycle.
- **Reset values.** Async `rst` forces all channels to IDLE, `cnt`=0, `sat`=0, `width_out`=0, `done`=0, `overflow`=0, `busy`=0, `prev`=1, synchroniser flops = inactive level. Reset mid-pulse discards the pulse without a `done`.

## Timing
- **Start latency.** A pulse seen at `s` on edge k (with `prev`=0) asserts `busy` after edge k.
- **End latency.** The first inactive `s` sample at edge m asserts `done` and updates `width_out` after edge m. The result is N = m−k.
- **Done width.** `done` lasts exactly one cycle. `busy` falls on the same edge that `done` rises.
- **Back-to-back pulses.** Minimum inactive gap between measurable pulses: 1 cycle. The edge after `done` may start a new count; `done` then drops while `busy` rises.
- **Pin-to-`s` delay.** 2 cycles with the synchroniser, 0 without.

## Configuration
- **Macro:** `PULSE_WIDTH_METER_SYNC_EN`.
- **Defined:** each `pulse_in` bit passes through a 2-flop synchroniser (reset to inactive level) before polarity/edge logic. Adds 2 cycles of latency to both start and end; measured widths are unchanged. Intended for asynchronous pins.
- **Undefined:** `s` = `pulse_in` directly. Only for inputs already synchronous to `clk`.

## Test plan
- **Single pulse.** CHANNELS=1, WIDTH=8, ACTIVE_HIGH=1, no SYNC: high pulse of 5 cycles → `done`=1 for one cycle, `width_out`=5, `overflow`=0, `busy` high for 5 cycles. Repeat with a 1-cycle pulse → `width_out`=1.
- **Saturation.** WIDTH=4: 20-cycle high pulse → `width_out`=15, `overflow`=1. A following 3-cycle pulse → `width_out`=3, `overflow`=0.
- **Low polarity.** ACTIVE_HIGH=0: input low for 7 cycles, high otherwise → `width_out`=7. High pulses produce no `done`.
- **Multi-channel.** CHANNELS=3: ch0 4 cycles, ch2 9 cycles, ending on the same edge → `done`=3'b101 in one cycle, slices read 4, 0 (reset value), 9.
- **Reset cases.**
  - Input high at reset release for 6 cycles → no `done`.
  - Async `rst` asserted mid-count → all outputs 0 immediately, no `done` afterwards.
  - Back-to-back pulses 3 high / 1 low / 2 high → `done` twice, results 3 then 2.
- **Synchroniser enabled.** With SYNC enabled, a 5-cycle pin pulse → `done` 2 cycles later than without the synchroniser, `width_out`=5.
